buffer_reader: RTL and testbench

Read-side controller for the circular register buffer whose write-enable masks come from the multi-slot write decoder. It tracks committed occupancy and owns the read pointer. It extracts READ_SIZE consecutive words (mod SIZE) per transfer into a registered output stage with a valid/ready handshake. It frees slots as they are consumed, and raises full/overflow back toward the writer.

---
 rtl/buffer_reader.sv | 88 ++++++++
 tb/tb_buffer_reader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_reader.sv
// buffer_reader: read side of a circular register buffer. Tracks committed occupancy,
// loads READ_SIZE-word transfers into a registered valid/ready stage, reports full/overflow.
module buffer_reader #(
    parameter int SIZE       = 8,
    parameter int WIDTH      = 16,
    parameter int WRITE_SIZE = 2,
    parameter int READ_SIZE  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SIZE*WIDTH-1:0]        mem_flat,
    input  logic                         wr_commit,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [READ_SIZE*WIDTH-1:0]   out_data,
    output logic [$clog2(SIZE)-1:0]      rd_ptr,
    output logic [SIZE-1:0]              rd_mask,
    output logic [$clog2(SIZE+1)-1:0]    count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow
);
    localparam int PW = $clog2(SIZE);
    localparam int CW = $clog2(SIZE + 1);
    localparam int P1 = PW + 1;
    localparam int C1 = CW + 1;

    typedef enum logic {IDLE, HOLD} state_t;
    state_t state;

    logic [WIDTH-1:0]           mem [SIZE];
    logic [PW-1:0]              idx [READ_SIZE];
    logic [READ_SIZE*WIDTH-1:0] load_data;
    logic [PW-1:0]              ptr_nx;
    logic [CW-1:0]              count_ld, count_nx;
    logic                       load, accept;

    // Sums stay below 2*SIZE, so one conditional subtract gives an exact wrap for any SIZE.
    function automatic logic [PW-1:0] wrap(input logic [P1-1:0] s);
        return s >= P1'(SIZE) ? PW'(s - P1'(SIZE)) : PW'(s);
    endfunction

    for (genvar i = 0; i < SIZE; i++) begin : g_mem
        assign mem[i] = mem_flat[i*WIDTH +: WIDTH];
    end

    for (genvar i = 0; i < READ_SIZE; i++) begin : g_rd
        assign idx[i] = wrap(P1'(rd_ptr) + P1'(i));
        assign load_data[i*WIDTH +: WIDTH] = mem[idx[i]];
    end

    always_comb begin
        rd_mask = '0;
        for (int k = 0; k < READ_SIZE; k++) rd_mask[idx[k]] = 1'b1;
    end

    assign out_valid = state == HOLD;
    assign load      = count >= CW'(READ_SIZE) && (state == IDLE || out_ready);
    assign count_ld  = load ? count - CW'(READ_SIZE) : count;
    // Slots freed by a same-cycle load make room for the incoming commit.
    assign accept    = wr_commit && (C1'(count_ld) + C1'(WRITE_SIZE) <= C1'(SIZE));
    assign count_nx  = accept ? count_ld + CW'(WRITE_SIZE) : count_ld;
    assign ptr_nx    = wrap(P1'(rd_ptr) + P1'(READ_SIZE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            count    <= '0;
            out_data <= '0;
            overflow <= 1'b0;
            empty    <= 1'b1;
            full     <= 1'b0;
        end else begin
            count    <= count_nx;
            empty    <= count_nx == '0;
            full     <= count_nx > CW'(SIZE - WRITE_SIZE);
            overflow <= overflow | (wr_commit & ~accept);
            if (load) begin
                out_data <= load_data;
                rd_ptr   <= ptr_nx;
                state    <= HOLD;
            end else if (out_ready) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_buffer_reader.sv
// tb_buffer_reader: scoreboard bench for buffer_reader, default sizes and a 7/3/2 asymmetric build.
module tb_buffer_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b0;

    logic [127:0] d_mem;
    logic         d_commit = 1'b0, d_ready = 1'b0;
    logic         d_valid, d_empty, d_full, d_ovf;
    logic [31:0]  d_data;
    logic [2:0]   d_ptr;
    logic [7:0]   d_mask;
    logic [3:0]   d_count;

    logic [111:0] a_mem;
    logic         a_commit = 1'b0, a_ready = 1'b0;
    logic         a_valid, a_empty, a_full, a_ovf;
    logic [31:0]  a_data;
    logic [2:0]   a_ptr;
    logic [6:0]   a_mask;
    logic [2:0]   a_count;

    buffer_reader dut_d (
        .clk(clk), .rst(rst), .mem_flat(d_mem), .wr_commit(d_commit), .out_ready(d_ready),
        .out_valid(d_valid), .out_data(d_data), .rd_ptr(d_ptr), .rd_mask(d_mask),
        .count(d_count), .empty(d_empty), .full(d_full), .overflow(d_ovf)
    );

    buffer_reader #(.SIZE(7), .WIDTH(16), .WRITE_SIZE(3), .READ_SIZE(2)) dut_a (
        .clk(clk), .rst(rst), .mem_flat(a_mem), .wr_commit(a_commit), .out_ready(a_ready),
        .out_valid(a_valid), .out_data(a_data), .rd_ptr(a_ptr), .rd_mask(a_mask),
        .count(a_count), .empty(a_empty), .full(a_full), .overflow(a_ovf)
    );

    int total = 0, bad = 0;
    logic [31:0] d_q[$], a_q[$];
    int d_pend = 0, d_nxt = 0, a_pend = 0, a_nxt = 0, a_seen = 0;

    function automatic logic [15:0] dw(input int k);
        return 16'hA000 + 16'(k % 8);
    endfunction

    function automatic logic [15:0] aw(input int k);
        return 16'hB000 + 16'(k % 7);
    endfunction

    task automatic d_push();
        d_pend += 2;
        while (d_pend >= 2) begin
            d_q.push_back({dw(d_nxt + 1), dw(d_nxt)});
            d_nxt += 2;
            d_pend -= 2;
        end
    endtask

    task automatic a_push();
        a_pend += 3;
        while (a_pend >= 2) begin
            a_q.push_back({aw(a_nxt + 1), aw(a_nxt)});
            a_nxt += 2;
            a_pend -= 2;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic d_commit_pulse(input bit acc);
        d_commit = 1'b1;
        if (acc) d_push();
        step();
        d_commit = 1'b0;
    endtask

    task automatic a_commit_pulse(input bit acc);
        a_commit = 1'b1;
        if (acc) a_push();
        step();
        a_commit = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        d_commit = 1'b0; d_ready = 1'b0; a_commit = 1'b0; a_ready = 1'b0;
        d_q.delete(); a_q.delete();
        d_pend = 0; d_nxt = 0; a_pend = 0; a_nxt = 0; a_seen = 0;
        step();
        rst = 1'b0;
    endtask

    // Transfers complete on the edge after a low-phase sample showing valid && ready.
    always @(negedge clk) begin : d_mon
        logic [31:0] e;
        if (!rst && d_valid && d_ready) begin
            total++;
            if (d_q.size() == 0) begin
                bad++;
                $display("FAIL d_stream: got %0h, nothing expected", d_data);
            end else begin
                e = d_q.pop_front();
                if (d_data !== e) begin bad++; $display("FAIL d_stream: got %0h want %0h", d_data, e); end
            end
        end
    end

    always @(negedge clk) begin : a_mon
        logic [31:0] e;
        if (!rst && a_valid && a_ready) begin
            total++;
            a_seen++;
            if (a_q.size() == 0) begin
                bad++;
                $display("FAIL a_stream: got %0h, nothing expected", a_data);
            end else begin
                e = a_q.pop_front();
                if (a_data !== e) begin bad++; $display("FAIL a_stream: got %0h want %0h", a_data, e); end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        total += 8;
        if (d_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", d_valid); end
        if (d_count !== 4'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", d_count); end
        if (d_ptr !== 3'd0) begin bad++; $display("FAIL rst_ptr: got %0d want 0", d_ptr); end
        if (d_mask !== 8'h03) begin bad++; $display("FAIL rst_mask: got %0h want 03", d_mask); end
        if (d_empty !== 1'b1 || d_full !== 1'b0) begin bad++; $display("FAIL rst_flags: got empty=%0b full=%0b want 1 0", d_empty, d_full); end
        if (d_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %0b want 0", d_ovf); end
        if (d_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %0h want 0", d_data); end
        if (a_mask !== 7'h03) begin bad++; $display("FAIL rst_amask: got %0h want 03", a_mask); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        d_ready = 1'b1;
        d_commit_pulse(1'b1);
        total += 2;
        if (d_count !== 4'd2) begin bad++; $display("FAIL basic_count1: got %0d want 2", d_count); end
        if (d_valid !== 1'b0) begin bad++; $display("FAIL basic_valid1: got %0b want 0", d_valid); end
        step();
        total += 4;
        if (d_valid !== 1'b1) begin bad++; $display("FAIL basic_valid2: got %0b want 1", d_valid); end
        if (d_data !== 32'hA001A000) begin bad++; $display("FAIL basic_data: got %0h want a001a000", d_data); end
        if (d_ptr !== 3'd2) begin bad++; $display("FAIL basic_ptr: got %0d want 2", d_ptr); end
        if (d_count !== 4'd0 || d_empty !== 1'b1) begin bad++; $display("FAIL basic_empty: got count=%0d empty=%0b want 0 1", d_count, d_empty); end
        step();
        total += 2;
        if (d_valid !== 1'b0) begin bad++; $display("FAIL basic_drop: got %0b want 0", d_valid); end
        if (d_q.size() != 0) begin bad++; $display("FAIL basic_left: got %0d pending want 0", d_q.size()); end
    endtask

    task automatic test_wrap();
        do_reset();
        d_ready = 1'b1;
        repeat (3) begin
            d_commit_pulse(1'b1);
            step();
            step();
        end
        total += 2;
        if (d_ptr !== 3'd6) begin bad++; $display("FAIL wrap_ptr6: got %0d want 6", d_ptr); end
        if (d_mask !== 8'hC0) begin bad++; $display("FAIL wrap_mask6: got %0h want c0", d_mask); end
        d_commit_pulse(1'b1);
        step();
        total += 3;
        if (d_data !== 32'hA007A006) begin bad++; $display("FAIL wrap_data: got %0h want a007a006", d_data); end
        if (d_ptr !== 3'd0) begin bad++; $display("FAIL wrap_ptr0: got %0d want 0", d_ptr); end
        if (d_mask !== 8'h03) begin bad++; $display("FAIL wrap_mask0: got %0h want 03", d_mask); end
        step();
        d_commit_pulse(1'b1);
        step();
        total += 2;
        if (d_data !== 32'hA001A000) begin bad++; $display("FAIL wrap_data2: got %0h want a001a000", d_data); end
        if (d_ptr !== 3'd2) begin bad++; $display("FAIL wrap_ptr2: got %0d want 2", d_ptr); end
        step();
    endtask

    task automatic test_simul();
        do_reset();
        d_commit_pulse(1'b1);
        d_commit_pulse(1'b1);
        total += 2;
        if (d_count !== 4'd2) begin bad++; $display("FAIL simul_count2: got %0d want 2", d_count); end
        if (d_valid !== 1'b1) begin bad++; $display("FAIL simul_valid: got %0b want 1", d_valid); end
        d_commit_pulse(1'b1);
        d_commit_pulse(1'b1);
        total += 2;
        if (d_count !== 4'd6) begin bad++; $display("FAIL simul_count6: got %0d want 6", d_count); end
        if (d_full !== 1'b0) begin bad++; $display("FAIL simul_full6: got %0b want 0", d_full); end
        d_commit_pulse(1'b1);
        total += 2;
        if (d_count !== 4'd8) begin bad++; $display("FAIL simul_count8: got %0d want 8", d_count); end
        if (d_full !== 1'b1) begin bad++; $display("FAIL simul_full8: got %0b want 1", d_full); end
        d_ready = 1'b1;
        d_commit_pulse(1'b1);
        total += 3;
        if (d_count !== 4'd8) begin bad++; $display("FAIL simul_count88: got %0d want 8", d_count); end
        if (d_ovf !== 1'b0) begin bad++; $display("FAIL simul_ovf: got %0b want 0", d_ovf); end
        if (d_data !== 32'hA003A002) begin bad++; $display("FAIL simul_data: got %0h want a003a002", d_data); end
        for (int n = 0; n < 40 && (d_q.size() != 0 || d_valid); n++) step();
        total += 2;
        if (d_q.size() != 0 || d_valid !== 1'b0) begin bad++; $display("FAIL simul_drain: got %0d pending valid=%0b want 0 0", d_q.size(), d_valid); end
        if (d_count !== 4'd0) begin bad++; $display("FAIL simul_count0: got %0d want 0", d_count); end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        repeat (5) d_commit_pulse(1'b1);
        total += 4;
        if (d_count !== 4'd8 || d_full !== 1'b1) begin bad++; $display("FAIL bp_full: got count=%0d full=%0b want 8 1", d_count, d_full); end
        if (d_data !== 32'hA001A000) begin bad++; $display("FAIL bp_hold: got %0h want a001a000", d_data); end
        if (d_ptr !== 3'd2) begin bad++; $display("FAIL bp_ptr: got %0d want 2", d_ptr); end
        if (d_ovf !== 1'b0) begin bad++; $display("FAIL bp_ovf0: got %0b want 0", d_ovf); end
        step();
        d_commit_pulse(1'b0);
        total += 3;
        if (d_data !== 32'hA001A000) begin bad++; $display("FAIL bp_stable: got %0h want a001a000", d_data); end
        if (d_count !== 4'd8) begin bad++; $display("FAIL bp_drop: got %0d want 8", d_count); end
        if (d_ovf !== 1'b1) begin bad++; $display("FAIL bp_ovf1: got %0b want 1", d_ovf); end
        d_ready = 1'b1;
        n = 0;
        while (d_valid && n < 40) begin step(); n++; end
        total += 4;
        if (n != 5) begin bad++; $display("FAIL bp_b2b: got %0d cycles want 5", n); end
        if (d_q.size() != 0) begin bad++; $display("FAIL bp_left: got %0d pending want 0", d_q.size()); end
        if (d_count !== 4'd0 || d_empty !== 1'b1) begin bad++; $display("FAIL bp_empty: got count=%0d empty=%0b want 0 1", d_count, d_empty); end
        if (d_ovf !== 1'b1) begin bad++; $display("FAIL bp_sticky: got %0b want 1", d_ovf); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (3) d_commit_pulse(1'b1);
        total += 2;
        if (d_count !== 4'd4) begin bad++; $display("FAIL mid_count4: got %0d want 4", d_count); end
        if (d_valid !== 1'b1) begin bad++; $display("FAIL mid_valid1: got %0b want 1", d_valid); end
        #2 rst = 1'b1;
        #1;
        d_q.delete();
        total += 5;
        if (d_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %0b want 0", d_valid); end
        if (d_count !== 4'd0 || d_empty !== 1'b1) begin bad++; $display("FAIL mid_count: got count=%0d empty=%0b want 0 1", d_count, d_empty); end
        if (d_ptr !== 3'd0 || d_mask !== 8'h03) begin bad++; $display("FAIL mid_ptr: got ptr=%0d mask=%0h want 0 03", d_ptr, d_mask); end
        if (d_ovf !== 1'b0) begin bad++; $display("FAIL mid_ovf: got %0b want 0", d_ovf); end
        if (d_data !== 32'h0) begin bad++; $display("FAIL mid_data: got %0h want 0", d_data); end
        step();
        rst = 1'b0;
        d_ready = 1'b1;
        repeat (3) step();
        total++;
        if (d_valid !== 1'b0) begin bad++; $display("FAIL mid_lost: got %0b want 0", d_valid); end
    endtask

    task automatic test_asym();
        do_reset();
        a_ready = 1'b1;
        repeat (3) a_commit_pulse(1'b1);
        for (int n = 0; n < 20 && (a_q.size() != 0 || a_valid); n++) step();
        repeat (3) step();
        total += 6;
        if (a_seen != 4) begin bad++; $display("FAIL asym_xfers: got %0d want 4", a_seen); end
        if (a_q.size() != 0) begin bad++; $display("FAIL asym_left: got %0d pending want 0", a_q.size()); end
        if (a_count !== 3'd1 || a_empty !== 1'b0) begin bad++; $display("FAIL asym_resid: got count=%0d empty=%0b want 1 0", a_count, a_empty); end
        if (a_valid !== 1'b0) begin bad++; $display("FAIL asym_idle: got %0b want 0", a_valid); end
        if (a_ptr !== 3'd1) begin bad++; $display("FAIL asym_ptr: got %0d want 1", a_ptr); end
        if (a_mask !== 7'b0000110) begin bad++; $display("FAIL asym_mask: got %0b want 0000110", a_mask); end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) d_mem[k*16 +: 16] = 16'hA000 + 16'(k);
        for (int k = 0; k < 7; k++) a_mem[k*16 +: 16] = 16'hB000 + 16'(k);
        test_reset();
        test_basic();
        test_wrap();
        test_simul();
        test_backpressure();
        test_reset_mid();
        test_asym();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
